// File: rtl/pgmflash_zxports.sv
// pgmflash_zxports
// ----------------------------------------------------------------------------
// ZX-bus IO responder for the pgmflash design. Decodes four IO ports and
// controls the 74*245 bus buffer. It also turns ZX data-port accesses into
// byte read/write requests for the ROM access sequencer. The requests use a
// req/ack handshake.
//
//   0x33  control/status : wr bit7 = soft init, bit6 = toggle led
//                          rd {init_in_progress, led, 5'b0, overrun}
//   0x3B  presence test  : 9-bit shift/invert register, rd treg[7:0]
//   0xB3  flash address  : three writes, high..low byte; the last one prefetches
//   0xBB  flash data     : wr issues a write, rd returns the prefetched byte and
//                          prefetches the next address
//
// Ports
//   clk_fpga, warmres_n         clock, synchronous active-low reset
//   zxa, zxiorq_n/rd_n/wr_n     ZX address low byte and strobes (asynchronous)
//   zxid                        buffered ZX data (inout)
//   zxbusin, zxbusena_n         245 direction / enable
//   zxblkiorq_n, zxgenwait_n    IORQ block (never blocks), ZX WAIT request
//   led, init_in_progress       diagnostic LED, init-busy flag
//   rom_req/we/addr/wdata       request to the ROM sequencer
//   rom_ack, rom_rdata          one-cycle completion pulse and read byte
//
// Build option
//   PGMFLASH_WAIT_EN : stall 0xBB accesses with ZX WAIT while a request is
//                      outstanding, instead of flagging overrun.
// ----------------------------------------------------------------------------
module pgmflash_zxports #(
    parameter int ADDR_W      = 19,
    parameter int INIT_CYCLES = 64
) (
    input  logic              clk_fpga,
    input  logic              warmres_n,
    input  logic [7:0]        zxa,
    input  logic              zxiorq_n,
    input  logic              zxrd_n,
    input  logic              zxwr_n,
    inout  wire  [7:0]        zxid,
    output logic              zxbusin,
    output logic              zxbusena_n,
    output logic              zxblkiorq_n,
    output logic              zxgenwait_n,
    output logic              led,
    output logic              init_in_progress,
    output logic              rom_req,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [7:0]        rom_wdata,
    input  logic              rom_ack,
    input  logic [7:0]        rom_rdata
);

    localparam int CNT_W = $clog2(INIT_CYCLES + 1);

    typedef enum logic [1:0] {
        PORT_CTRL,
        PORT_TEST,
        PORT_ADDR,
        PORT_DATA
    } port_e;

    // Strobe vector layout: {iorq_n, rd_n, wr_n}
    logic [2:0]        strb_meta_q, strb_meta_d, strb_s_q, strb_s_d;
    logic [7:0]        zxa_meta_q, zxa_meta_d, zxa_s_q, zxa_s_d;
    logic              rd_act_q, rd_act_d, wr_act_q, wr_act_d;
    logic [7:0]        zxid_q, zxid_d;
    logic              acc_hit_q, acc_hit_d;
    port_e             acc_port_q, acc_port_d;
    logic              rd_evt_q, rd_evt_d;
    port_e             rd_evt_port_q, rd_evt_port_d;
    logic              led_q, led_d;
    logic [CNT_W-1:0]  init_cnt_q, init_cnt_d;
    logic [8:0]        treg_q, treg_d;
    logic [1:0]        phase_q, phase_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              overrun_q, overrun_d;
    logic              pv_q, pv_d;
    logic [7:0]        pdata_q, pdata_d;
    logic              rom_req_q, rom_req_d;
    logic              rom_we_q, rom_we_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [7:0]        rom_wdata_q, rom_wdata_d;

    logic              rd_act, wr_act, hit, init_busy, busy;
    logic              wr_fall, rd_fall;
    port_e             port;
    logic [7:0]        rd_data;
    logic              issue_rd, issue_wr;
    logic [ADDR_W-1:0] issue_addr;

    assign rd_act    = ~strb_s_q[2] & ~strb_s_q[1];
    assign wr_act    = ~strb_s_q[2] & ~strb_s_q[0];
    assign init_busy = (init_cnt_q != '0);
    assign busy      = rom_req_q;

    // The port latched during the access stays valid after the strobe ends.
    // The edge events below therefore use it, not the live address.
    assign wr_fall = wr_act_q & ~wr_act & acc_hit_q;
    assign rd_fall = rd_act_q & ~rd_act & acc_hit_q;

    always_comb begin
        hit  = 1'b1;
        port = PORT_CTRL;
        case (zxa_s_q)
            8'h33:   port = PORT_CTRL;
            8'h3B:   port = PORT_TEST;
            8'hB3:   port = PORT_ADDR;
            8'hBB:   port = PORT_DATA;
            default: hit  = 1'b0;
        endcase
    end

    always_comb begin
        rd_data = 8'h00;
        if (hit) begin
            case (port)
                PORT_CTRL: rd_data = {init_busy, led_q, 5'b0, overrun_q};
                PORT_TEST: rd_data = treg_q[7:0];
                PORT_ADDR: rd_data = 8'hFF;
                PORT_DATA: rd_data = pv_q ? pdata_q : 8'hFF;
                default:   rd_data = 8'h00;
            endcase
        end
    end

    assign zxid        = (rd_act && hit) ? rd_data : 8'hzz;
    assign zxbusena_n  = ~(hit & (rd_act | wr_act));
    assign zxbusin     = ~rd_act;
    assign zxblkiorq_n = 1'b1;

`ifdef PGMFLASH_WAIT_EN
    // A read prefetch or a write is outstanding exactly while rom_req is high.
    // Holding WAIT until it falls means the stalled access ends after the
    // sequencer is free again.
    assign zxgenwait_n = ~(hit && (port == PORT_DATA) && (rd_act || wr_act)
                           && rom_req_q && !init_busy);
`else
    assign zxgenwait_n = 1'b1;
`endif

    always_comb begin
        strb_meta_d   = {zxiorq_n, zxrd_n, zxwr_n};
        strb_s_d      = strb_meta_q;
        zxa_meta_d    = zxa;
        zxa_s_d       = zxa_meta_q;
        rd_act_d      = rd_act;
        wr_act_d      = wr_act;
        zxid_d        = zxid;
        acc_hit_d     = acc_hit_q;
        acc_port_d    = acc_port_q;
        rd_evt_d      = rd_fall;
        rd_evt_port_d = acc_port_q;
        led_d         = led_q;
        init_cnt_d    = init_busy ? init_cnt_q - 1'b1 : '0;
        treg_d        = treg_q;
        phase_d       = phase_q;
        addr_d        = addr_q;
        overrun_d     = overrun_q;
        pv_d          = pv_q;
        pdata_d       = pdata_q;
        rom_req_d     = rom_req_q;
        rom_we_d      = rom_we_q;
        rom_addr_d    = rom_addr_q;
        rom_wdata_d   = rom_wdata_q;
        issue_rd      = 1'b0;
        issue_wr      = 1'b0;
        issue_addr    = addr_q;

        if (rd_act || wr_act) begin
            acc_hit_d  = hit;
            acc_port_d = port;
        end

        // Acks arriving with no request outstanding (e.g. after a reset that
        // cut a transaction short) are ignored.
        if (rom_req_q && rom_ack) begin
            rom_req_d = 1'b0;
            if (!rom_we_q) begin
                pdata_d = rom_rdata;
                pv_d    = 1'b1;
            end
        end

        if (wr_fall) begin
            case (acc_port_q)
                PORT_CTRL: begin
                    if (zxid_q[7]) begin
                        init_cnt_d = CNT_W'(INIT_CYCLES);
                        phase_d    = 2'd0;
                        pv_d       = 1'b0;
                        overrun_d  = 1'b0;
                        led_d      = 1'b0;
                    end else if (zxid_q[6]) begin
                        led_d = ~led_q;
                    end
                end
                PORT_TEST: treg_d = {~zxid_q, treg_q[8]};
                PORT_ADDR: begin
                    if (!init_busy) begin
                        case (phase_q)
                            2'd0: begin
                                addr_d[ADDR_W-1:16] = zxid_q[ADDR_W-17:0];
                                phase_d             = 2'd1;
                            end
                            2'd1: begin
                                addr_d[15:8] = zxid_q;
                                phase_d      = 2'd2;
                            end
                            default: begin
                                addr_d[7:0] = zxid_q;
                                phase_d     = 2'd0;
                                issue_rd    = 1'b1;
                                issue_addr  = {addr_q[ADDR_W-1:8], zxid_q};
                            end
                        endcase
                    end
                end
                PORT_DATA: begin
                    if (!init_busy) begin
                        pv_d       = 1'b0;
                        issue_wr   = 1'b1;
                        issue_addr = addr_q;
                        addr_d     = addr_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (rd_evt_q && (rd_evt_port_q == PORT_DATA) && !init_busy) begin
            pv_d       = 1'b0;
            addr_d     = addr_q + 1'b1;
            issue_rd   = 1'b1;
            issue_addr = addr_q + 1'b1;
        end

        if ((issue_rd || issue_wr) && !busy) begin
            rom_req_d  = 1'b1;
            rom_we_d   = issue_wr;
            rom_addr_d = issue_addr;
            if (issue_wr) begin
                rom_wdata_d = zxid_q;
            end
        end
`ifndef PGMFLASH_WAIT_EN
        // The new request is dropped. The one in flight keeps running.
        if ((issue_rd || issue_wr) && busy) begin
            overrun_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk_fpga) begin
        if (!warmres_n) begin
            strb_meta_q   <= 3'b111;
            strb_s_q      <= 3'b111;
            zxa_meta_q    <= 8'h00;
            zxa_s_q       <= 8'h00;
            rd_act_q      <= 1'b0;
            wr_act_q      <= 1'b0;
            zxid_q        <= 8'h00;
            acc_hit_q     <= 1'b0;
            acc_port_q    <= PORT_CTRL;
            rd_evt_q      <= 1'b0;
            rd_evt_port_q <= PORT_CTRL;
            led_q         <= 1'b0;
            init_cnt_q    <= CNT_W'(INIT_CYCLES);
            treg_q        <= 9'd0;
            phase_q       <= 2'd0;
            addr_q        <= '0;
            overrun_q     <= 1'b0;
            pv_q          <= 1'b0;
            pdata_q       <= 8'h00;
            rom_req_q     <= 1'b0;
            rom_we_q      <= 1'b0;
            rom_addr_q    <= '0;
            rom_wdata_q   <= 8'h00;
        end else begin
            strb_meta_q   <= strb_meta_d;
            strb_s_q      <= strb_s_d;
            zxa_meta_q    <= zxa_meta_d;
            zxa_s_q       <= zxa_s_d;
            rd_act_q      <= rd_act_d;
            wr_act_q      <= wr_act_d;
            zxid_q        <= zxid_d;
            acc_hit_q     <= acc_hit_d;
            acc_port_q    <= acc_port_d;
            rd_evt_q      <= rd_evt_d;
            rd_evt_port_q <= rd_evt_port_d;
            led_q         <= led_d;
            init_cnt_q    <= init_cnt_d;
            treg_q        <= treg_d;
            phase_q       <= phase_d;
            addr_q        <= addr_d;
            overrun_q     <= overrun_d;
            pv_q          <= pv_d;
            pdata_q       <= pdata_d;
            rom_req_q     <= rom_req_d;
            rom_we_q      <= rom_we_d;
            rom_addr_q    <= rom_addr_d;
            rom_wdata_q   <= rom_wdata_d;
        end
    end

    assign led              = led_q;
    assign init_in_progress = init_busy;
    assign rom_req          = rom_req_q;
    assign rom_we           = rom_we_q;
    assign rom_addr         = rom_addr_q;
    assign rom_wdata        = rom_wdata_q;

endmodule

// File: tb/tb_pgmflash_zxports.sv
// Testbench for pgmflash_zxports: ZX IO cycles driven as tasks, with the ROM
// sequencer acknowledged by hand. Expected values come from a small model:
// treg rule, led state, flash address, prefetch state and a byte memory.
module tb_pgmflash_zxports;

    localparam int ADDR_W      = 19;
    localparam int INIT_CYCLES = 64;

    logic              clk = 1'b0;
    logic              warmres_n = 1'b0;
    logic [7:0]        zxa = 8'h00;
    logic              zxiorq_n = 1'b1, zxrd_n = 1'b1, zxwr_n = 1'b1;
    wire  [7:0]        zxid;
    logic              zxbusin, zxbusena_n, zxblkiorq_n, zxgenwait_n;
    logic              led, init_in_progress, rom_req, rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_wdata;
    logic              rom_ack = 1'b0;
    logic [7:0]        rom_rdata = 8'h00;

    logic              tb_drv = 1'b0;
    logic [7:0]        tb_d = 8'h00;
    assign zxid = tb_drv ? tb_d : 8'hzz;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pgmflash_zxports #(.ADDR_W(ADDR_W), .INIT_CYCLES(INIT_CYCLES)) dut (
        .clk_fpga(clk), .warmres_n(warmres_n), .zxa(zxa),
        .zxiorq_n(zxiorq_n), .zxrd_n(zxrd_n), .zxwr_n(zxwr_n), .zxid(zxid),
        .zxbusin(zxbusin), .zxbusena_n(zxbusena_n), .zxblkiorq_n(zxblkiorq_n),
        .zxgenwait_n(zxgenwait_n), .led(led), .init_in_progress(init_in_progress),
        .rom_req(rom_req), .rom_we(rom_we), .rom_addr(rom_addr),
        .rom_wdata(rom_wdata), .rom_ack(rom_ack), .rom_rdata(rom_rdata)
    );

    // Flash memory model: unwritten bytes have an address-derived pattern.
    logic [7:0] mem [int];
    function automatic logic [7:0] byte_at(input logic [ADDR_W-1:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return a[7:0] ^ 8'h3C;
    endfunction

    task automatic zx_begin(input logic [7:0] port, input logic is_wr, input logic [7:0] d);
        @(negedge clk);
        zxa = port;
        if (is_wr) begin
            tb_drv = 1'b1;
            tb_d   = d;
        end
        repeat (3) @(negedge clk);
        zxiorq_n = 1'b0;
        if (is_wr) zxwr_n = 1'b0;
        else       zxrd_n = 1'b0;
    endtask

    task automatic zx_end();
        zxiorq_n = 1'b1;
        zxrd_n   = 1'b1;
        zxwr_n   = 1'b1;
        repeat (5) @(negedge clk);
        tb_drv = 1'b0;
        zxa    = 8'h00;
        repeat (3) @(negedge clk);
    endtask

    task automatic zx_write(input logic [7:0] port, input logic [7:0] d);
        zx_begin(port, 1'b1, d);
        repeat (6) @(negedge clk);
        zx_end();
        $display("[%0t] zx write port=%02h data=%02h", $time, port, d);
    endtask

    task automatic zx_read(input logic [7:0] port, output logic [7:0] d);
        zx_begin(port, 1'b0, 8'h00);
        repeat (6) @(negedge clk);
        d = zxid;
        zx_end();
        $display("[%0t] zx read  port=%02h data=%02h", $time, port, d);
    endtask

    task automatic set_addr(input logic [ADDR_W-1:0] a);
        zx_write(8'hB3, {5'b0, a[18:16]});
        zx_write(8'hB3, a[15:8]);
        zx_write(8'hB3, a[7:0]);
    endtask

    task automatic ack_req(input logic [7:0] d);
        int n = 0;
        while (rom_req !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rom_req !== 1'b1) begin
            errors++;
            $display("FAIL ack_timeout: rom_req=%b required 1", rom_req);
        end else begin
            rom_rdata = d;
            rom_ack   = 1'b1;
            @(negedge clk);
            rom_ack   = 1'b0;
            rom_rdata = 8'h00;
            $display("[%0t] rom ack we=%b addr=%05h rdata=%02h", $time, rom_we, rom_addr, d);
        end
    endtask

    task automatic wait_init();
        int n = 0;
        while (init_in_progress !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (init_in_progress !== 1'b0) begin
            errors++;
            $display("FAIL init_timeout: init_in_progress=%b required 0", init_in_progress);
        end
    endtask

    task automatic do_reset();
        warmres_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 warmres_n = 1'b1;
    endtask

    task automatic test_reset();
        int n = 0;
        logic [7:0] r;
        warmres_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rom_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", rom_req); end
        checks++; if ({zxbusin, zxbusena_n, zxblkiorq_n, zxgenwait_n} !== 4'b1111) begin
            errors++; $display("FAIL rst_bus: got %b want 1111", {zxbusin, zxbusena_n, zxblkiorq_n, zxgenwait_n}); end
        checks++; if (led !== 1'b0 || init_in_progress !== 1'b1) begin
            errors++; $display("FAIL rst_led_init: got led=%b init=%b want 0/1", led, init_in_progress); end
        warmres_n = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (init_in_progress === 1'b1) n++;
            else break;
        end
        checks++; if (n != INIT_CYCLES) begin errors++; $display("FAIL init_len: got %0d want %0d", n, INIT_CYCLES); end
        zx_read(8'h33, r);
        checks++; if (r !== 8'h00) begin errors++; $display("FAIL ctrl_idle: got %02h want 00", r); end
        zx_write(8'h33, 8'h80);
        checks++; if (init_in_progress !== 1'b1) begin errors++; $display("FAIL soft_init: got %b want 1", init_in_progress); end
        zx_read(8'h33, r);
        checks++; if (r !== 8'h80) begin errors++; $display("FAIL ctrl_init: got %02h want 80", r); end
        wait_init();
        zx_read(8'h33, r);
        checks++; if (r !== 8'h00) begin errors++; $display("FAIL ctrl_after_init: got %02h want 00", r); end
    endtask

    task automatic test_led();
        logic led_m = 1'b0;
        logic [7:0] r;
        for (int i = 0; i < 20; i++) begin
            zx_write(8'h33, 8'h40);
            led_m = ~led_m;
            checks++; if (led !== led_m) begin errors++; $display("FAIL led_pin[%0d]: got %b want %b", i, led, led_m); end
            zx_read(8'h33, r);
            checks++; if (r !== {1'b0, led_m, 6'b0}) begin
                errors++; $display("FAIL led_status[%0d]: got %02h want %02h", i, r, {1'b0, led_m, 6'b0}); end
        end
        zx_write(8'h33, 8'h40);
        zx_write(8'h33, 8'hC0);
        checks++; if (led !== 1'b0 || init_in_progress !== 1'b1) begin
            errors++; $display("FAIL init_beats_led: got led=%b init=%b want 0/1", led, init_in_progress); end
        wait_init();
    endtask

    task automatic test_bus_buffer();
        logic [7:0] r;
        zx_begin(8'h3B, 1'b0, 8'h00);
        repeat (4) @(negedge clk);
        checks++; if ({zxbusin, zxbusena_n} !== 2'b00) begin errors++; $display("FAIL buf_read: got %b want 00", {zxbusin, zxbusena_n}); end
        zx_end();
        zx_begin(8'h3B, 1'b1, 8'h12);
        repeat (4) @(negedge clk);
        checks++; if ({zxbusin, zxbusena_n} !== 2'b10) begin errors++; $display("FAIL buf_write: got %b want 10", {zxbusin, zxbusena_n}); end
        zx_end();
        zx_begin(8'h55, 1'b0, 8'h00);
        repeat (4) @(negedge clk);
        checks++; if ({zxbusin, zxbusena_n} !== 2'b01) begin errors++; $display("FAIL buf_nohit: got %b want 01", {zxbusin, zxbusena_n}); end
        zx_end();
        zx_read(8'hB3, r);
        checks++; if (r !== 8'hFF) begin errors++; $display("FAIL addr_port_read: got %02h want FF", r); end
    endtask

    task automatic test_treg();
        logic [8:0] treg_m = 9'd0;
        logic [7:0] r, d;
        do_reset();
        zx_read(8'h3B, r);
        checks++; if (r !== 8'h00) begin errors++; $display("FAIL treg_reset: got %02h want 00", r); end
        zx_write(8'h3B, 8'hA5);
        treg_m = {~8'hA5, treg_m[8]};
        zx_read(8'h3B, r);
        checks++; if (r !== 8'hB4) begin errors++; $display("FAIL treg_a5: got %02h want B4", r); end
        zx_write(8'h3B, 8'h3C);
        treg_m = {~8'h3C, treg_m[8]};
        zx_read(8'h3B, r);
        checks++; if (r !== treg_m[7:0]) begin errors++; $display("FAIL treg_3c: got %02h want %02h", r, treg_m[7:0]); end
        for (int i = 0; i < 256; i++) begin
            d = 8'($urandom);
            zx_write(8'h3B, d);
            treg_m = {~d, treg_m[8]};
            zx_read(8'h3B, r);
            checks++; if (r !== treg_m[7:0]) begin
                errors++; $display("FAIL treg_rand[%0d]: d=%02h got %02h want %02h", i, d, r, treg_m[7:0]); end
        end
    endtask

    task automatic test_addr_prefetch();
        logic [7:0] r;
        wait_init();
        set_addr(19'h12345);
        checks++; if (rom_req !== 1'b1 || rom_we !== 1'b0 || rom_addr !== 19'h12345) begin
            errors++; $display("FAIL addr_prefetch: got req=%b we=%b addr=%05h want 1/0/12345", rom_req, rom_we, rom_addr); end
        ack_req(8'h5A);
        checks++; if (rom_req !== 1'b0) begin errors++; $display("FAIL req_drop: got %b want 0", rom_req); end
        zx_read(8'hBB, r);
        checks++; if (r !== 8'h5A) begin errors++; $display("FAIL prefetch_data: got %02h want 5A", r); end
        checks++; if (rom_req !== 1'b1 || rom_we !== 1'b0 || rom_addr !== 19'h12346) begin
            errors++; $display("FAIL next_prefetch: got req=%b we=%b addr=%05h want 1/0/12346", rom_req, rom_we, rom_addr); end
        ack_req(8'h00);
    endtask

    task automatic test_wrap();
        logic [7:0] r;
        set_addr(19'h7FFFF);
        ack_req(8'h11);
        zx_write(8'hBB, 8'hC3);
        checks++; if (rom_req !== 1'b1 || rom_we !== 1'b1 || rom_addr !== 19'h7FFFF || rom_wdata !== 8'hC3) begin
            errors++; $display("FAIL wr_req: got req=%b we=%b addr=%05h wdata=%02h want 1/1/7FFFF/C3",
                               rom_req, rom_we, rom_addr, rom_wdata); end
        ack_req(8'h00);
        set_addr(19'h7FFFF);
        ack_req(8'h77);
        zx_read(8'hBB, r);
        checks++; if (r !== 8'h77) begin errors++; $display("FAIL top_data: got %02h want 77", r); end
        checks++; if (rom_req !== 1'b1 || rom_we !== 1'b0 || rom_addr !== 19'h00000) begin
            errors++; $display("FAIL addr_wrap: got req=%b we=%b addr=%05h want 1/0/00000", rom_req, rom_we, rom_addr); end
        ack_req(8'h00);
    endtask

    task automatic test_random_bb();
        logic [ADDR_W-1:0] m_addr;
        logic              m_pv;
        logic [7:0]        m_pdata, r, d, exp;
        m_addr = ($urandom_range(0, 1) == 1) ? (19'h7FFF0 + 19'($urandom_range(0, 15))) : 19'($urandom);
        set_addr(m_addr);
        checks++; if (rom_req !== 1'b1 || rom_we !== 1'b0 || rom_addr !== m_addr) begin
            errors++; $display("FAIL rnd_setaddr: got addr=%05h want %05h", rom_addr, m_addr); end
        ack_req(byte_at(m_addr));
        m_pv = 1'b1;
        m_pdata = byte_at(m_addr);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                d = 8'($urandom);
                zx_write(8'hBB, d);
                checks++; if (rom_req !== 1'b1 || rom_we !== 1'b1 || rom_addr !== m_addr || rom_wdata !== d) begin
                    errors++; $display("FAIL rnd_wr[%0d]: got req=%b we=%b addr=%05h wdata=%02h want 1/1/%05h/%02h",
                                       i, rom_req, rom_we, rom_addr, rom_wdata, m_addr, d); end
                ack_req(8'h00);
                mem[int'(m_addr)] = d;
                m_addr = m_addr + 1'b1;
                m_pv = 1'b0;
            end else begin
                zx_read(8'hBB, r);
                exp = m_pv ? m_pdata : 8'hFF;
                checks++; if (r !== exp) begin errors++; $display("FAIL rnd_rd[%0d]: got %02h want %02h", i, r, exp); end
                m_addr = m_addr + 1'b1;
                checks++; if (rom_req !== 1'b1 || rom_we !== 1'b0 || rom_addr !== m_addr) begin
                    errors++; $display("FAIL rnd_pf[%0d]: got req=%b we=%b addr=%05h want 1/0/%05h",
                                       i, rom_req, rom_we, rom_addr, m_addr); end
                ack_req(byte_at(m_addr));
                m_pv = 1'b1;
                m_pdata = byte_at(m_addr);
            end
        end
    endtask

    task automatic test_overrun();
        logic [7:0] r;
        set_addr(19'h00100);
        ack_req(8'h00);
        zx_write(8'hBB, 8'h11);
        zx_begin(8'hBB, 1'b1, 8'h22);
        repeat (6) @(negedge clk);
`ifdef PGMFLASH_WAIT_EN
        checks++; if (zxgenwait_n !== 1'b0) begin errors++; $display("FAIL wait_assert: got %b want 0", zxgenwait_n); end
        ack_req(8'h00);
        repeat (2) @(negedge clk);
        checks++; if (zxgenwait_n !== 1'b1) begin errors++; $display("FAIL wait_release: got %b want 1", zxgenwait_n); end
        zx_end();
        checks++; if (rom_req !== 1'b1 || rom_addr !== 19'h00101 || rom_wdata !== 8'h22) begin
            errors++; $display("FAIL stalled_wr: got req=%b addr=%05h wdata=%02h want 1/00101/22", rom_req, rom_addr, rom_wdata); end
        ack_req(8'h00);
        zx_read(8'h33, r);
        checks++; if (r !== 8'h00) begin errors++; $display("FAIL no_overrun: got %02h want 00", r); end
`else
        checks++; if (zxgenwait_n !== 1'b1) begin errors++; $display("FAIL wait_tied: got %b want 1", zxgenwait_n); end
        zx_end();
        checks++; if (rom_req !== 1'b1 || rom_addr !== 19'h00100 || rom_wdata !== 8'h11) begin
            errors++; $display("FAIL dropped_wr: got req=%b addr=%05h wdata=%02h want 1/00100/11", rom_req, rom_addr, rom_wdata); end
        zx_read(8'h33, r);
        checks++; if (r !== 8'h01) begin errors++; $display("FAIL overrun_flag: got %02h want 01", r); end
        ack_req(8'h00);
`endif
        zx_read(8'hBB, r);
        checks++; if (r !== 8'hFF) begin errors++; $display("FAIL pv_cleared: got %02h want FF", r); end
        checks++; if (rom_req !== 1'b1 || rom_we !== 1'b0 || rom_addr !== 19'h00103) begin
            errors++; $display("FAIL addr_advance: got req=%b we=%b addr=%05h want 1/0/00103", rom_req, rom_we, rom_addr); end
        // Reset with the prefetch still outstanding, then a late ack.
        @(negedge clk);
        warmres_n = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (rom_req !== 1'b0) begin errors++; $display("FAIL rst_mid_req: got %b want 0", rom_req); end
        @(negedge clk);
        rom_ack = 1'b1;
        rom_rdata = 8'h99;
        @(negedge clk);
        rom_ack = 1'b0;
        warmres_n = 1'b1;
        @(negedge clk);
        rom_ack = 1'b1;
        @(negedge clk);
        rom_ack = 1'b0;
        rom_rdata = 8'h00;
        zx_read(8'h33, r);
        checks++; if (r !== 8'h80) begin errors++; $display("FAIL ctrl_after_rst: got %02h want 80", r); end
        zx_read(8'hBB, r);
        checks++; if (r !== 8'hFF) begin errors++; $display("FAIL late_ack_ignored: got %02h want FF", r); end
        checks++; if (rom_req !== 1'b0) begin errors++; $display("FAIL init_ignore: got %b want 0", rom_req); end
        wait_init();
        zx_read(8'hBB, r);
        checks++; if (rom_req !== 1'b1 || rom_we !== 1'b0 || rom_addr !== 19'h00001) begin
            errors++; $display("FAIL post_init_pf: got req=%b we=%b addr=%05h want 1/0/00001", rom_req, rom_we, rom_addr); end
        ack_req(8'h00);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: time=%0t required completion earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_led();
        test_bus_buffer();
        test_treg();
        test_addr_prefetch();
        test_wrap();
        test_random_bb();
        test_overrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
